ex_stage_mc: RTL and testbench
==============================

// Module: ex_stage_mc
// PURPOSE
//  Parametrised execute stage: per-operand forwarding mux over NUM_FWD bypass sources, single-cycle integer ALU
//  and an iterative shift-based MUL/DIV unit. Sits between the ID/EX and EX/MEM boundaries.
//  Registered EX/MEM result bundle; valid/ready on both sides (stall); flush aborts in-flight work.
// PARAMETERS
//  XLEN     32  datapath width (>=8)
//  NUM_FWD  3   number of forwarding sources (>=1)
// PORTS
//  clk           in   1             clock, rising edge
//  reset         in   1             synchronous, active-low (0 = reset)
//  flush         in   1             kill accepted/in-flight op and held output
//  in_valid      in   1             ID/EX bundle valid
//  in_ready      out  1             stage can accept bundle this cycle
//  in_ir         in   32            instruction word
//  in_a, in_b    in   XLEN each     register-file rs1/rs2 values
//  in_imm        in   XLEN          I-type immediate, pre-extended
//  in_op         in   5             op: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//                                   16 MUL 17 DIV 18 DIVU 19 REM 20 REMU; others -> result 0
//  in_b_sel      in   2             0 rs2, 1 in_imm, 2 store imm sext({ir[31:25],ir[11:7]})
//  fwd_sel_a     in   NUM_FWD       one-hot-ish rs1 bypass select, lowest set index wins
//  fwd_sel_b     in   NUM_FWD       rs2 bypass select, same rule
//  fwd_data      in   NUM_FWD*XLEN  bypass values, source i at [i*XLEN +: XLEN]
//  out_valid     out  1             EX/MEM bundle valid
//  out_ready     in   1             MEM consumes bundle
//  out_ir        out  32            registered IR
//  out_result    out  XLEN          ALU / MUL / DIV result
//  out_store     out  XLEN          forwarded rs2 (store data)
//  busy          out  1             iterative op in progress
// BEHAVIOUR
//  Reset (reset==0 at edge): out_valid=0, out_ir=0, out_result=0, out_store=0, busy=0, FSM->IDLE. Mid-op reset discards op.
//  Operand A = selected fwd_data if any fwd_sel_a bit set, else in_a. rs2 value likewise from fwd_sel_b/in_b.
//  Operand B = rs2 value (sel 0), in_imm (1), store imm (2); sel 3 -> rs2 value. out_store always = rs2 value.
//  Operands and IR captured at acceptance; later fwd/in changes have no effect.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready && !flush.
//  FSM: IDLE -(accept, op<16)-> IDLE, result registered, out_valid=1 next edge (latency 1).
//       IDLE -(accept, op 16..20)-> BUSY, busy=1; XLEN iterations (1 bit/cycle) -> DONE.
//       DONE: write result, out_valid=1 on the edge leaving DONE -> IDLE. MUL/DIV latency = XLEN+2 edges.
//       DONE waits while out_valid && !out_ready (output held stable).
//  out_valid clears on out_ready when no new result lands same edge; drain+accept same edge is back-to-back.
//  Shifts use operand B[log2(XLEN)-1:0]. SLT signed, SLTU unsigned; result 1/0 zero-extended.
//  MUL: low XLEN bits of product (sign-agnostic).
//  DIV/REM signed truncate toward zero; remainder takes dividend sign.
//  Divide by zero: DIV/DIVU -> all ones, REM/REMU -> dividend.
//  Signed overflow (-2^(XLEN-1) / -1): DIV -> dividend, REM -> 0.
//  flush (priority over everything but reset): out_valid=0, FSM->IDLE, busy=0, same-cycle in_valid ignored;
//       in_ready may be 1 the cycle after flush.
//  Outputs hold while out_valid && !out_ready. No X on any output after reset.
// TESTING
//  1 ADD, in_a=5, imm=7, b_sel=1, out_ready=1 -> next cycle out_valid=1, out_result=12, out_ir=in_ir.
//  2 fwd_sel_a=3'b110, fwd_data src1=0x10, src2=0x20, SUB, rs2=1 -> out_result=0x0F (lowest index wins).
//  3 DIV -7/2 -> out_valid after 34 edges (XLEN=32), -3; REM -> -1; DIVU x/0 -> 0xFFFFFFFF; 0x80000000 DIV -1 -> 0x80000000.
//  4 out_ready=0 holding result, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 + new op -> back-to-back results.
//  5 MUL 0xFFFF*0x10001 (XLEN=32): flush at iteration 10 -> busy=0, no out_valid; next op accepted the following cycle.
//  6 reset low mid-DIV -> all outputs 0 at next edge; store b_sel=2, ir[31:25]=0x7F, ir[11:7]=0x1F -> operand B=-1.

Source files
------------

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage: bypass muxes, single-cycle ALU, iterative MUL/DIV, registered EX/MEM bundle
module ex_stage_mc #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_ir,
    input  logic [XLEN-1:0]         in_a,
    input  logic [XLEN-1:0]         in_b,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [4:0]              in_op,
    input  logic [1:0]              in_b_sel,
    input  logic [NUM_FWD-1:0]      fwd_sel_a,
    input  logic [NUM_FWD-1:0]      fwd_sel_b,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_ir,
    output logic [XLEN-1:0]         out_result,
    output logic [XLEN-1:0]         out_store,
    output logic                    busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic            r_out_valid;
    logic [31:0]     r_out_ir;
    logic [XLEN-1:0] r_out_result;
    logic [XLEN-1:0] r_out_store;

    logic [4:0]      r_op;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dz;
    logic [31:0]     r_p_ir;
    logic [XLEN-1:0] r_p_store;

    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_opb;
    logic [11:0]     w_simm12;
    logic [XLEN-1:0] w_simm;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_md_res;
    logic            w_is_md;
    logic            w_sdiv;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_accept;
    logic            w_fire;
    logic            w_land;
    logic [XLEN:0]   w_div_rs;
    logic [XLEN:0]   w_div_df;

    // Descending scan so the lowest set select index is the one left standing
    always_comb begin
        w_opa = in_a;
        w_rs2 = in_b;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_sel_a[i]) w_opa = fwd_data[i*XLEN +: XLEN];
            if (fwd_sel_b[i]) w_rs2 = fwd_data[i*XLEN +: XLEN];
        end
    end

    assign w_simm12 = {in_ir[31:25], in_ir[11:7]};
    assign w_simm   = XLEN'($signed(w_simm12));

    always_comb begin
        w_opb = w_rs2;
        case (in_b_sel)
            2'd1:    w_opb = in_imm;
            2'd2:    w_opb = w_simm;
            default: w_opb = w_rs2;
        endcase
    end

    assign w_shamt = w_opb[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (in_op)
            5'd0:    w_alu = w_opa + w_opb;
            5'd1:    w_alu = w_opa - w_opb;
            5'd2:    w_alu = w_opa & w_opb;
            5'd3:    w_alu = w_opa | w_opb;
            5'd4:    w_alu = w_opa ^ w_opb;
            5'd5:    w_alu = w_opa << w_shamt;
            5'd6:    w_alu = w_opa >> w_shamt;
            5'd7:    w_alu = $signed(w_opa) >>> w_shamt;
            5'd8:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_opa) < $signed(w_opb)};
            5'd9:    w_alu = {{(XLEN-1){1'b0}}, w_opa < w_opb};
            default: w_alu = '0;
        endcase
    end

    assign w_is_md = (in_op >= 5'd16) && (in_op <= 5'd20);
    assign w_sdiv  = (in_op == 5'd17) || (in_op == 5'd19);
    assign w_a_neg = w_sdiv && w_opa[XLEN-1];
    assign w_b_neg = w_sdiv && w_opb[XLEN-1];
    assign w_abs_a = w_a_neg ? ('0 - w_opa) : w_opa;
    assign w_abs_b = w_b_neg ? ('0 - w_opb) : w_opb;

    // Restoring divide step: r_acc is the partial remainder, r_x shifts dividend out and quotient in
    assign w_div_rs = {r_acc, r_x[XLEN-1]};
    assign w_div_df = w_div_rs - {1'b0, r_y};

    // Magnitude divide with divisor 0 already yields all-ones / dividend; only signed DIV needs the override
    always_comb begin
        w_md_res = '0;
        case (r_op)
            5'd16:   w_md_res = r_acc;
            5'd17:   w_md_res = r_dz ? '1 : (r_neg_q ? ('0 - r_x) : r_x);
            5'd18:   w_md_res = r_x;
            5'd19:   w_md_res = r_neg_r ? ('0 - r_acc) : r_acc;
            5'd20:   w_md_res = r_acc;
            default: w_md_res = '0;
        endcase
    end

    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_fire   = (r_state == S_DONE) && (!r_out_valid || out_ready);
    assign w_land   = (w_accept && !w_is_md) || w_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_ir     <= '0;
            r_out_result <= '0;
            r_out_store  <= '0;
            r_op         <= '0;
            r_acc        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_cnt        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dz         <= 1'b0;
            r_p_ir       <= '0;
            r_p_store    <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept && !w_is_md) begin
                r_out_ir     <= in_ir;
                r_out_result <= w_alu;
                r_out_store  <= w_rs2;
            end else if (w_fire) begin
                r_out_ir     <= r_p_ir;
                r_out_result <= w_md_res;
                r_out_store  <= r_p_store;
            end

            if (w_land) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_md) begin
                        r_state   <= S_BUSY;
                        r_op      <= in_op;
                        r_p_ir    <= in_ir;
                        r_p_store <= w_rs2;
                        r_cnt     <= CW'(XLEN);
                        r_acc     <= '0;
                        r_x       <= (in_op == 5'd16) ? w_opa : w_abs_a;
                        r_y       <= (in_op == 5'd16) ? w_opb : w_abs_b;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dz      <= (w_opb == '0);
                    end
                end
                S_BUSY: begin
                    if (r_op == 5'd16) begin
                        if (r_y[0]) r_acc <= r_acc + r_x;
                        r_x <= r_x << 1;
                        r_y <= r_y >> 1;
                    end else if (!w_div_df[XLEN]) begin
                        r_acc <= w_div_df[XLEN-1:0];
                        r_x   <= {r_x[XLEN-2:0], 1'b1};
                    end else begin
                        r_acc <= w_div_rs[XLEN-1:0];
                        r_x   <= {r_x[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (w_fire) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ir     = r_out_ir;
    assign out_result = r_out_result;
    assign out_store  = r_out_store;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - table, random and corner-sequence checks for ex_stage_mc (XLEN=32, NUM_FWD=3)
module tb_ex_stage_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_ir = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_op = '0;
    logic [1:0]  in_b_sel = '0;
    logic [2:0]  fwd_sel_a = '0;
    logic [2:0]  fwd_sel_b = '0;
    logic [95:0] fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_ir;
    logic [31:0] out_result;
    logic [31:0] out_store;
    logic        busy;

    int n_vec = 0;
    int n_mis = 0;

    ex_stage_mc #(.XLEN(32), .NUM_FWD(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_op(in_op), .in_b_sel(in_b_sel),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
        .out_result(out_result), .out_store(out_store), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [1:0]  bsel;
        logic [31:0] ir;
        logic [2:0]  fsa;
        logic [2:0]  fsb;
        logic [95:0] fd;
        logic [31:0] exp_res;
        logic [31:0] exp_st;
        int          lat;
    } vec_t;

    vec_t tv[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [1:0] bsel, input logic [31:0] ir,
                                input logic [2:0] fsa, input logic [2:0] fsb, input logic [95:0] fd,
                                input logic [31:0] exp_res, input logic [31:0] exp_st, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.bsel = bsel; v.ir = ir;
        v.fsa = fsa; v.fsb = fsb; v.fd = fd;
        v.exp_res = exp_res; v.exp_st = exp_st; v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] sel, input logic [95:0] fd, input logic [31:0] dflt);
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) return fd[i*32 +: 32];
        end
        return dflt;
    endfunction

    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  r = $signed(a) >>> b[4:0];
            5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd16: r = a * b;
            5'd17: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else r = $signed(a) / $signed(b);
            end
            5'd18: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd19: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else r = $signed(a) % $signed(b);
            end
            5'd20: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t        v;
        int          k;
        logic [31:0] rs1, rs2, opb, sim;
        k = $urandom_range(0, 15);
        v.op = (k < 10) ? 5'(k) : ((k < 15) ? 5'(16 + k - 10) : 5'd25);
        v.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
        case ($urandom_range(0, 5))
            0:       v.b = '0;
            1:       v.b = 32'($urandom_range(0, 9)) - 32'd4;
            default: v.b = $urandom;
        endcase
        if ($urandom_range(0, 9) == 0) begin
            v.a = 32'h8000_0000;
            v.b = 32'hFFFF_FFFF;
        end
        v.imm = $urandom;
        v.bsel = 2'($urandom_range(0, 3));
        v.ir = $urandom;
        v.fsa = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        v.fsb = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        v.fd = {$urandom, $urandom, $urandom};
        rs1 = pick(v.fsa, v.fd, v.a);
        rs2 = pick(v.fsb, v.fd, v.b);
        sim = {{20{v.ir[31]}}, v.ir[31:25], v.ir[11:7]};
        opb = (v.bsel == 2'd1) ? v.imm : ((v.bsel == 2'd2) ? sim : rs2);
        v.exp_res = ref_result(v.op, rs1, opb);
        v.exp_st = rs2;
        v.lat = (v.op >= 5'd16 && v.op <= 5'd20) ? 34 : 1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_op = v.op; in_a = v.a; in_b = v.b; in_imm = v.imm; in_b_sel = v.bsel;
        in_ir = v.ir; fwd_sel_a = v.fsa; fwd_sel_b = v.fsb; fwd_data = v.fd;
    endtask

    task automatic scramble();
        in_a = $urandom; in_b = $urandom; in_imm = $urandom; in_ir = $urandom;
        in_op = 5'($urandom); in_b_sel = 2'($urandom);
        fwd_sel_a = 3'($urandom); fwd_sel_b = 3'($urandom);
        fwd_data = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int edges;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        drive(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        edges = 1;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
        end
        chk({tag, ".lat"}, 32'(edges), 32'(v.lat));
        chk({tag, ".res"}, out_result, v.exp_res);
        chk({tag, ".store"}, out_store, v.exp_st);
        chk({tag, ".ir"}, out_ir, v.ir);
    endtask

    task automatic count_stale(input string tag);
        int seen;
        seen = 0;
        tick();
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t v;

        tv.push_back(mk(5'd0,  32'd5,         32'h99,        32'd7,   2'd1, 32'h1234_5013, 3'b000, 3'b000, '0, 32'd12,        32'h99, 1));
        tv.push_back(mk(5'd1,  32'hDEAD,      32'd1,         32'd0,   2'd0, 32'h4000_0033, 3'b110, 3'b000,
                        {32'h20, 32'h10, 32'hAAAA}, 32'h0F, 32'd1, 1));
        tv.push_back(mk(5'd17, 32'hFFFF_FFF9, 32'd2,         32'd0,   2'd0, 32'h0220_4033, 3'b000, 3'b000, '0, 32'hFFFF_FFFD, 32'd2, 34));
        tv.push_back(mk(5'd19, 32'hFFFF_FFF9, 32'd2,         32'd0,   2'd0, 32'h0220_6033, 3'b000, 3'b000, '0, 32'hFFFF_FFFF, 32'd2, 34));
        tv.push_back(mk(5'd18, 32'h1234,      32'd0,         32'd0,   2'd0, 32'h0220_5033, 3'b000, 3'b000, '0, 32'hFFFF_FFFF, 32'd0, 34));
        tv.push_back(mk(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,   2'd0, 32'h0000_0011, 3'b000, 3'b000, '0, 32'h8000_0000, 32'hFFFF_FFFF, 34));
        tv.push_back(mk(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,   2'd0, 32'h0000_0012, 3'b000, 3'b000, '0, 32'd0,         32'hFFFF_FFFF, 34));
        tv.push_back(mk(5'd19, 32'hFFFF_FFF7, 32'd0,         32'd0,   2'd0, 32'h0000_0013, 3'b000, 3'b000, '0, 32'hFFFF_FFF7, 32'd0, 34));
        tv.push_back(mk(5'd17, 32'hFFFF_FFF7, 32'd0,         32'd0,   2'd0, 32'h0000_0014, 3'b000, 3'b000, '0, 32'hFFFF_FFFF, 32'd0, 34));
        tv.push_back(mk(5'd20, 32'd100,       32'd7,         32'd0,   2'd0, 32'h0000_0015, 3'b000, 3'b000, '0, 32'd2,         32'd7, 34));
        tv.push_back(mk(5'd18, 32'd100,       32'd7,         32'd0,   2'd0, 32'h0000_0016, 3'b000, 3'b000, '0, 32'd14,        32'd7, 34));
        tv.push_back(mk(5'd16, 32'h0000_FFFF, 32'h0001_0001, 32'd0,   2'd0, 32'h0000_0017, 3'b000, 3'b000, '0, 32'hFFFF_FFFF, 32'h0001_0001, 34));
        tv.push_back(mk(5'd16, 32'hFFFF_FFFD, 32'd7,         32'd0,   2'd0, 32'h0000_0018, 3'b000, 3'b000, '0, 32'hFFFF_FFEB, 32'd7, 34));
        tv.push_back(mk(5'd17, 32'd7,         32'hFFFF_FFFE, 32'd0,   2'd0, 32'h0000_0019, 3'b000, 3'b000, '0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34));
        tv.push_back(mk(5'd19, 32'd7,         32'hFFFF_FFFE, 32'd0,   2'd0, 32'h0000_001A, 3'b000, 3'b000, '0, 32'd1,         32'hFFFF_FFFE, 34));
        tv.push_back(mk(5'd0,  32'd5,         32'h55,        32'h100, 2'd2, 32'hFE00_0F80, 3'b000, 3'b000, '0, 32'd4,         32'h55, 1));
        tv.push_back(mk(5'd7,  32'h8000_0000, 32'h24,        32'd0,   2'd0, 32'h0000_0020, 3'b000, 3'b000, '0, 32'hF800_0000, 32'h24, 1));
        tv.push_back(mk(5'd5,  32'd1,         32'd33,        32'd0,   2'd0, 32'h0000_0021, 3'b000, 3'b000, '0, 32'd2,         32'd33, 1));
        tv.push_back(mk(5'd8,  32'hFFFF_FFFF, 32'd1,         32'd0,   2'd0, 32'h0000_0022, 3'b000, 3'b000, '0, 32'd1,         32'd1, 1));
        tv.push_back(mk(5'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,   2'd0, 32'h0000_0023, 3'b000, 3'b000, '0, 32'd0,         32'd1, 1));
        tv.push_back(mk(5'd3,  32'hF0,        32'h1234,      32'd0,   2'd0, 32'h0000_0024, 3'b000, 3'b100,
                        {32'h0F, 32'h77, 32'h66}, 32'hFF, 32'h0F, 1));
        tv.push_back(mk(5'd12, 32'd9,         32'd9,         32'd0,   2'd0, 32'h0000_0025, 3'b000, 3'b000, '0, 32'd0,         32'd9, 1));
        tv.push_back(mk(5'd25, 32'd9,         32'd9,         32'd0,   2'd0, 32'h0000_0026, 3'b000, 3'b000, '0, 32'd0,         32'd9, 1));
        tv.push_back(mk(5'd0,  32'd1,         32'd2,         32'd100, 2'd3, 32'h0000_0027, 3'b000, 3'b000, '0, 32'd3,         32'd2, 1));

        reset = 1'b0;
        repeat (3) tick();
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_ir", out_ir, 32'd0);
        chk("reset.out_result", out_result, 32'd0);
        chk("reset.out_store", out_store, 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < tv.size(); i++) run_vec(tv[i], $sformatf("tab%0d", i));

        for (int i = 0; i < 150; i++) begin
            v = rand_vec();
            run_vec(v, $sformatf("rnd%0d", i));
        end
        tick();

        out_ready = 1'b0;
        drive(mk(5'd0, 32'd1, 32'd2, 32'd0, 2'd0, 32'hA1, 3'b0, 3'b0, '0, 32'd3, 32'd2, 1));
        in_valid = 1'b1;
        tick();
        chk("stall.first_valid", 32'(out_valid), 32'd1);
        chk("stall.first_res", out_result, 32'd3);
        drive(mk(5'd0, 32'd10, 32'd20, 32'd0, 2'd0, 32'hA2, 3'b0, 3'b0, '0, 32'd30, 32'd20, 1));
        repeat (3) begin
            tick();
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk("stall.hold_valid", 32'(out_valid), 32'd1);
            chk("stall.hold_res", out_result, 32'd3);
            chk("stall.hold_ir", out_ir, 32'hA1);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("b2b.valid", 32'(out_valid), 32'd1);
        chk("b2b.res", out_result, 32'd30);
        chk("b2b.ir", out_ir, 32'hA2);
        tick();
        chk("b2b.drain", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(mk(5'd0, 32'd4, 32'd4, 32'd0, 2'd0, 32'hB1, 3'b0, 3'b0, '0, 32'd8, 32'd4, 1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("flushhold.pre", 32'(out_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushhold.valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        drive(mk(5'd0, 32'd4, 32'd4, 32'd0, 2'd0, 32'hB2, 3'b0, 3'b0, '0, 32'd8, 32'd4, 1));
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flushin.valid", 32'(out_valid), 32'd0);
        chk("flushin.busy", 32'(busy), 32'd0);
        tick();
        chk("flushin.valid2", 32'(out_valid), 32'd0);

        drive(mk(5'd16, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'd0, 32'hC1, 3'b0, 3'b0, '0, 32'hFFFF_FFFF, 32'h0001_0001, 34));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("flushmul.busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushmul.busy", 32'(busy), 32'd0);
        chk("flushmul.valid", 32'(out_valid), 32'd0);
        run_vec(mk(5'd0, 32'd6, 32'd7, 32'd0, 2'd0, 32'hC2, 3'b0, 3'b0, '0, 32'd13, 32'd7, 1), "flushmul.next");
        count_stale("flushmul.stale");

        drive(mk(5'd17, 32'd100, 32'd3, 32'd0, 2'd0, 32'hD1, 3'b0, 3'b0, '0, 32'd33, 32'd3, 34));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("rstdiv.valid", 32'(out_valid), 32'd0);
        chk("rstdiv.busy", 32'(busy), 32'd0);
        chk("rstdiv.ir", out_ir, 32'd0);
        chk("rstdiv.result", out_result, 32'd0);
        chk("rstdiv.store", out_store, 32'd0);
        reset = 1'b1;
        count_stale("rstdiv.stale");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end
endmodule
